// File: rtl/horner_sched_pkg.sv
// Shared constants for the Horner sequencer: FSM encoding, Q-format widths,
// and coefficient indices matching the external coefficient mux.
package horner_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Q2.14 inputs/coefficients, Q7.25 accumulator; Q2.14 -> Q7.25 is a shift by 11
  localparam int Q_WIDTHIN  = 16;
  localparam int Q_WIDTHOUT = 32;
  localparam int Q_ALIGN    = 11;

  localparam logic [2:0] COEF_A0 = 3'd0;
  localparam logic [2:0] COEF_A1 = 3'd1;
  localparam logic [2:0] COEF_A2 = 3'd2;
  localparam logic [2:0] COEF_A3 = 3'd3;
  localparam logic [2:0] COEF_A4 = 3'd4;
  localparam logic [2:0] COEF_A5 = 3'd5;

endpackage

// File: rtl/horner_sched.sv
// Horner-rule sequencer for the shared mult32x16/addr32p16 datapath: one
// multiply or add per cycle, valid/ready on both the x and y streams.
module horner_sched
  import horner_sched_pkg::*;
#(
  parameter int WIDTHIN  = Q_WIDTHIN,
  parameter int WIDTHOUT = Q_WIDTHOUT,
  parameter int ORDER    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WIDTHIN-1:0]  i_x,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WIDTHOUT-1:0] o_y,
  output logic [2:0]          dp_coef_sel,
  input  logic [WIDTHIN-1:0]  dp_coef,
  output logic [WIDTHOUT-1:0] dp_mul_a,
  output logic [WIDTHIN-1:0]  dp_mul_b,
  output logic                dp_out_sel,
  input  logic [WIDTHOUT-1:0] dp_mul_res,
  output logic [WIDTHOUT-1:0] dp_add_a,
  input  logic [WIDTHOUT-1:0] dp_add_res,
  output logic                busy
);

  localparam logic [2:0] K_TOP = 3'(ORDER);

  state_e              r_state;
  logic [WIDTHIN-1:0]  r_x;
  logic [WIDTHOUT-1:0] r_acc;
  logic [WIDTHOUT-1:0] r_y;
  logic [2:0]          r_k;
  logic                r_first;
  logic                r_valid;
  logic                w_busy;
  logic                w_accept;

  assign w_busy   = (r_state == ST_MUL) | (r_state == ST_ADD);
  assign o_ready  = reset & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & i_ready));
  assign w_accept = i_valid & o_ready;

  // Mux select comes only from registered state so dp_coef never feeds back into it
  assign dp_coef_sel = w_busy ? r_k : K_TOP;
  assign dp_mul_a    = r_first ? {{(WIDTHOUT-WIDTHIN){1'b0}}, dp_coef} : r_acc;
  assign dp_mul_b    = r_x;
  assign dp_out_sel  = ~r_first;
  assign dp_add_a    = r_acc;
  assign busy        = w_busy;
  assign o_valid     = r_valid;
  assign o_y         = r_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_k     <= '0;
      r_first <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x     <= i_x;
            r_k     <= K_TOP;
            r_first <= 1'b1;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc   <= dp_mul_res;
          r_k     <= r_k - 3'd1;
          r_first <= 1'b0;
          r_state <= ST_ADD;
        end
        ST_ADD: begin
          r_acc <= dp_add_res;
          if (r_k == 3'd0) begin
            r_y     <= dp_add_res;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_MUL;
          end
        end
        ST_DONE: begin
          // Handing off the result and accepting the next x share one edge
          if (i_ready) begin
            r_valid <= 1'b0;
            if (i_valid) begin
              r_x     <= i_x;
              r_k     <= K_TOP;
              r_first <= 1'b1;
              r_state <= ST_MUL;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
